// File: rtl/ddr3_arb_pkg.sv
// Shared types and constants for the two-port DDR3MI command arbiter.
package ddr3_arb_pkg;

    localparam int BURST_W = 6;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WDATA = 2'd2
    } arb_state_e;

    // One outstanding read: owning port and beats still to come minus one.
    typedef struct packed {
        logic               port;
        logic [BURST_W-1:0] remaining;
    } tag_t;

endpackage

// File: rtl/ddr3_cmd_arbiter_if.sv
// DDR3MI user-interface bundle; master is the arbiter side, slave the DDR3MI side.
interface ddr3_cmd_arbiter_if
    import ddr3_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128
);
    logic                    I_cmd_ready;
    logic [2:0]              O_cmd;
    logic                    O_cmd_en;
    logic [BURST_W-1:0]      O_app_burst_number;
    logic [ADDR_WIDTH-1:0]   O_addr;
    logic                    I_wr_data_rdy;
    logic                    O_wr_data_en;
    logic                    O_wr_data_end;
    logic [DATA_WIDTH-1:0]   O_wr_data;
    logic [DATA_WIDTH/8-1:0] O_wr_data_mask;
    logic                    I_rd_data_valid;
    logic [DATA_WIDTH-1:0]   I_rd_data;

    modport master (
        input  I_cmd_ready, I_wr_data_rdy, I_rd_data_valid, I_rd_data,
        output O_cmd, O_cmd_en, O_app_burst_number, O_addr,
               O_wr_data_en, O_wr_data_end, O_wr_data, O_wr_data_mask
    );

    modport slave (
        output I_cmd_ready, I_wr_data_rdy, I_rd_data_valid, I_rd_data,
        input  O_cmd, O_cmd_en, O_app_burst_number, O_addr,
               O_wr_data_en, O_wr_data_end, O_wr_data, O_wr_data_mask
    );
endinterface

// File: rtl/ddr3_arb_tag_fifo.sv
// Read-tag FIFO: records issuing port and beat count per outstanding read,
// with an in-place decrement of the head entry's remaining count.
module ddr3_arb_tag_fifo
    import ddr3_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  tag_t push_data,
    input  logic pop,
    input  logic dec,
    output tag_t head,
    output logic full,
    output logic empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_idx_s, rd_idx_s;
    tag_t          mem_q [DEPTH];
    tag_t          mem_d [DEPTH];

    assign wr_idx_s = wr_ptr_q[AW-1:0];
    assign rd_idx_s = rd_ptr_q[AW-1:0];
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx_s == rd_idx_s);
    assign head     = mem_q[rd_idx_s];

    // Next pointers and storage; pop and decrement only ever target the head.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_idx_s] = push_data;
            wr_ptr_d        = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (!empty && pop) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end else if (!empty && dec) begin
            mem_d[rd_idx_s].remaining = mem_q[rd_idx_s].remaining - 6'd1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: rtl/ddr3_cmd_arbiter.sv
// Round-robin arbiter sharing one DDR3MI user port between two DMA requesters;
// issues whole transactions and routes read beats back through a tag FIFO.
module ddr3_cmd_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128,
    parameter int TAG_DEPTH  = 4
) (
    input  logic                      I_clk,
    input  logic                      I_rst,
    input  logic                      I_init_calib_complete,
    input  logic [1:0]                I_req,
    input  logic [1:0]                I_rnw,
    input  logic [2*ADDR_WIDTH-1:0]   I_addr,
    input  logic [2*BURST_W-1:0]      I_burst,
    output logic [1:0]                O_gnt,
    input  logic [1:0]                I_wr_en,
    input  logic [2*DATA_WIDTH-1:0]   I_wr_data,
    input  logic [2*DATA_WIDTH/8-1:0] I_wr_mask,
    output logic [1:0]                O_wr_rdy,
    output logic [1:0]                O_rd_valid,
    output logic [DATA_WIDTH-1:0]     O_rd_data,
    output logic                      O_err,
    ddr3_cmd_arbiter_if.master        ddr
);
    localparam int MW = DATA_WIDTH / 8;

    arb_state_e            state_q, state_d;
    logic                  sel_q, sel_d, rnw_q, rnw_d, rr_last_q, rr_last_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BURST_W-1:0]    burst_q, burst_d, beat_cnt_q, beat_cnt_d;
    logic [1:0]            rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  err_q, err_d;

    logic [1:0] elig_s;
    logic       pick_s, cmd_acc_s, wr_beat_s, in_wdata_s;
    logic       fifo_full_s, fifo_empty_s, fifo_pop_s, fifo_dec_s;
    tag_t       fifo_head_s, push_tag_s;

    // A read may only be issued while there is room to remember its owner.
    assign elig_s     = {2{I_init_calib_complete}} & I_req & (~I_rnw | {2{~fifo_full_s}});
    assign cmd_acc_s  = (state_q == ST_CMD) & ddr.I_cmd_ready;
    assign in_wdata_s = (state_q == ST_WDATA);
    assign wr_beat_s  = in_wdata_s & I_wr_en[sel_q] & ddr.I_wr_data_rdy;
    assign push_tag_s = '{port: sel_q, remaining: burst_q};

    assign O_gnt                  = {cmd_acc_s & sel_q, cmd_acc_s & ~sel_q};
    assign O_wr_rdy               = {in_wdata_s & sel_q & ddr.I_wr_data_rdy,
                                     in_wdata_s & ~sel_q & ddr.I_wr_data_rdy};
    assign ddr.O_cmd_en           = (state_q == ST_CMD);
    assign ddr.O_cmd              = rnw_q ? CMD_READ : CMD_WRITE;
    assign ddr.O_addr             = addr_q;
    assign ddr.O_app_burst_number = burst_q;
    assign ddr.O_wr_data_en       = wr_beat_s;
    assign ddr.O_wr_data_end      = wr_beat_s & (beat_cnt_q == 6'd0);
    assign ddr.O_wr_data          = sel_q ? I_wr_data[DATA_WIDTH +: DATA_WIDTH] : I_wr_data[0 +: DATA_WIDTH];
    assign ddr.O_wr_data_mask     = sel_q ? I_wr_mask[MW +: MW] : I_wr_mask[0 +: MW];
    assign O_rd_valid             = rd_valid_q;
    assign O_rd_data              = rd_data_q;
    assign O_err                  = err_q;

    // Transaction sequencing: pick a port, hold the command until accepted, stream write beats.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        rnw_d      = rnw_q;
        addr_d     = addr_q;
        burst_d    = burst_q;
        beat_cnt_d = beat_cnt_q;
        rr_last_d  = rr_last_q;
        pick_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (elig_s != 2'b00) begin
                    pick_s  = (elig_s == 2'b11) ? ~rr_last_q : elig_s[1];
                    sel_d   = pick_s;
                    rnw_d   = I_rnw[pick_s];
                    addr_d  = pick_s ? I_addr[ADDR_WIDTH +: ADDR_WIDTH] : I_addr[0 +: ADDR_WIDTH];
                    burst_d = pick_s ? I_burst[BURST_W +: BURST_W] : I_burst[0 +: BURST_W];
                    state_d = ST_CMD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (ddr.I_cmd_ready) begin
                    rr_last_d = sel_q;
                    if (rnw_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_cnt_d = burst_q;
                        state_d    = ST_WDATA;
                    end
                end else begin
                    state_d = ST_CMD;
                end
            end
            ST_WDATA: begin
                if (wr_beat_s && (beat_cnt_q == 6'd0)) begin
                    state_d = ST_IDLE;
                end else if (wr_beat_s) begin
                    beat_cnt_d = beat_cnt_q - 6'd1;
                end else begin
                    state_d = ST_WDATA;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read return routing: owner comes from the FIFO head, unmatched beats raise the sticky error.
    always_comb begin
        rd_valid_d = 2'b00;
        rd_data_d  = rd_data_q;
        err_d      = err_q;
        fifo_pop_s = 1'b0;
        fifo_dec_s = 1'b0;
        if (ddr.I_rd_data_valid && !fifo_empty_s) begin
            rd_valid_d[fifo_head_s.port] = 1'b1;
            rd_data_d                    = ddr.I_rd_data;
            fifo_pop_s                   = (fifo_head_s.remaining == 6'd0);
            fifo_dec_s                   = (fifo_head_s.remaining != 6'd0);
        end else if (ddr.I_rd_data_valid) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Arbiter and read-return registers.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q    <= ST_IDLE;
            sel_q      <= 1'b0;
            rnw_q      <= 1'b0;
            addr_q     <= '0;
            burst_q    <= '0;
            beat_cnt_q <= '0;
            rr_last_q  <= 1'b1;
            rd_valid_q <= 2'b00;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            rnw_q      <= rnw_d;
            addr_q     <= addr_d;
            burst_q    <= burst_d;
            beat_cnt_q <= beat_cnt_d;
            rr_last_q  <= rr_last_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
        end
    end

    ddr3_arb_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clk       (I_clk),
        .rst       (I_rst),
        .push      (cmd_acc_s & rnw_q),
        .push_data (push_tag_s),
        .pop       (fifo_pop_s),
        .dec       (fifo_dec_s),
        .head      (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );
endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// Scenario bench for ddr3_cmd_arbiter; read routing is predicted from a queue of issued read owners.
module tb_ddr3_cmd_arbiter;
    import ddr3_arb_pkg::*;

    logic         clk = 1'b0;
    logic         I_rst, I_init_calib_complete;
    logic [1:0]   I_req, I_rnw, O_gnt, I_wr_en, O_wr_rdy, O_rd_valid;
    logic [55:0]  I_addr;
    logic [11:0]  I_burst;
    logic [255:0] I_wr_data;
    logic [31:0]  I_wr_mask;
    logic [127:0] O_rd_data;
    logic         O_err;

    ddr3_cmd_arbiter_if #(.ADDR_WIDTH(28), .DATA_WIDTH(128)) ddr ();

    ddr3_cmd_arbiter #(.ADDR_WIDTH(28), .DATA_WIDTH(128), .TAG_DEPTH(4)) dut (
        .I_clk(clk), .I_rst(I_rst), .I_init_calib_complete(I_init_calib_complete),
        .I_req(I_req), .I_rnw(I_rnw), .I_addr(I_addr), .I_burst(I_burst), .O_gnt(O_gnt),
        .I_wr_en(I_wr_en), .I_wr_data(I_wr_data), .I_wr_mask(I_wr_mask), .O_wr_rdy(O_wr_rdy),
        .O_rd_valid(O_rd_valid), .O_rd_data(O_rd_data), .O_err(O_err), .ddr(ddr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];       // expected owner of each future read beat, in order
    int gnt_cnt[2] = '{0, 0};

    always begin
        @(negedge clk);
        #2;
        if (O_gnt[0] === 1'b1) gnt_cnt[0]++;
        if (O_gnt[1] === 1'b1) gnt_cnt[1]++;
    end

    function automatic logic [127:0] r128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic issue_read(input int p, input int burst, output bit ok);
        logic [27:0] a;
        bit got;
        a = 28'($urandom);
        got = 1'b0;
        ok  = 1'b0;
        I_rnw[p] = 1'b1;
        I_addr[p*28 +: 28] = a;
        I_burst[p*6 +: 6] = 6'(burst);
        I_req[p] = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            #1;
            if (O_gnt[p] === 1'b1) begin
                got = 1'b1;
                ok = (ddr.O_cmd === CMD_READ) && (ddr.O_addr === a) && (ddr.O_app_burst_number === 6'(burst));
                for (int b = 0; b <= burst; b++) exp_q.push_back(p);
            end
        end
        @(negedge clk);
        I_req[p] = 1'b0;
    endtask

    task automatic run_write(input int p, input int burst, input logic [27:0] a, input int stall,
                             output bit gnt_ok, output bit addr_ok, output int beats,
                             output bit end_ok, output bit data_ok, output bit other_ok);
        int limit;
        gnt_ok = 1'b0; addr_ok = 1'b1; beats = 0; end_ok = 1'b1; data_ok = 1'b1; other_ok = 1'b1;
        I_rnw[p] = 1'b0;
        I_addr[p*28 +: 28] = a;
        I_burst[p*6 +: 6] = 6'(burst);
        I_req[p] = 1'b1;
        I_wr_en = 2'b11;
        limit = (burst + 1) * 4 + 40;
        for (int c = 0; c < limit && beats < burst + 1; c++) begin
            @(negedge clk);
            if (gnt_ok) I_req[p] = 1'b0;
            I_wr_data = {r128(), r128()};
            I_wr_mask = $urandom;
            if (stall == 0)      ddr.I_wr_data_rdy = 1'b1;
            else if (stall == 1) ddr.I_wr_data_rdy = ((c % 2) == 1);
            else                 ddr.I_wr_data_rdy = ($urandom_range(0, 3) != 0);
            #1;
            if (O_gnt[p] === 1'b1) begin
                gnt_ok = 1'b1;
                if (ddr.O_cmd !== CMD_WRITE || ddr.O_addr !== a || ddr.O_app_burst_number !== 6'(burst)) addr_ok = 1'b0;
            end
            if (O_wr_rdy[1-p] !== 1'b0) other_ok = 1'b0;
            if (ddr.O_wr_data_en === 1'b1) begin
                beats++;
                if (ddr.O_wr_data !== I_wr_data[p*128 +: 128] || ddr.O_wr_data_mask !== I_wr_mask[p*16 +: 16]
                    || ddr.I_wr_data_rdy !== 1'b1) data_ok = 1'b0;
                if (ddr.O_wr_data_end !== (beats == burst + 1)) end_ok = 1'b0;
            end else if (ddr.O_wr_data_end !== 1'b0) begin
                end_ok = 1'b0;
            end
        end
        repeat (3) begin
            @(negedge clk);
            I_req[p] = 1'b0;
            ddr.I_wr_data_rdy = 1'b1;
            #1;
            if (ddr.O_wr_data_en === 1'b1) beats++;
        end
        I_wr_en = 2'b00;
    endtask

    task automatic drain_reads(input int n, output int bad, output logic [1:0] act_v, output logic [1:0] want_v);
        int pp;
        logic [127:0] pd;
        logic [1:0] ev;
        bad = 0; pp = -1; pd = '0; act_v = 2'b00; want_v = 2'b00;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (i < n) begin
                ddr.I_rd_data_valid = 1'b1;
                ddr.I_rd_data = r128();
            end else begin
                ddr.I_rd_data_valid = 1'b0;
            end
            #1;
            if (i > 0) begin
                ev = (pp < 0) ? 2'b00 : ((pp == 1) ? 2'b10 : 2'b01);
                if (O_rd_valid !== ev || (pp >= 0 && O_rd_data !== pd)) begin
                    if (bad == 0) begin act_v = O_rd_valid; want_v = ev; end
                    bad++;
                end
            end
            if (i < n) begin
                pd = ddr.I_rd_data;
                pp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            end
        end
    endtask

    task automatic test_reset();
        I_rst = 1'b1;
        repeat (3) @(negedge clk);
        I_rst = 1'b0;
        #1;
        n_tests++;
        if ({O_gnt, O_wr_rdy, O_rd_valid, ddr.O_cmd_en, ddr.O_wr_data_en, ddr.O_wr_data_end, O_err} !== 9'd0) begin
            n_fail++; $display("FAIL reset_flags got %b want 0", {O_gnt, O_wr_rdy, O_rd_valid, ddr.O_cmd_en, ddr.O_wr_data_en, ddr.O_wr_data_end, O_err});
        end
        n_tests++;
        if ({ddr.O_cmd, ddr.O_addr, ddr.O_app_burst_number} !== 37'd0) begin
            n_fail++; $display("FAIL reset_cmd got %h want 0", {ddr.O_cmd, ddr.O_addr, ddr.O_app_burst_number});
        end
        n_tests++;
        if (O_rd_data !== 128'd0) begin
            n_fail++; $display("FAIL reset_rd_data got %h want 0", O_rd_data);
        end
    endtask

    task automatic test_calib_gate();
        int seen, first, second, bad;
        logic [1:0] av, wv;
        bit drop0, drop1;
        seen = 0; first = -1; second = -1; drop0 = 1'b0; drop1 = 1'b0;
        I_init_calib_complete = 1'b0;
        I_rnw = 2'b11; I_burst = 12'd0; I_addr = {28'($urandom), 28'($urandom)};
        I_req = 2'b11;
        repeat (100) begin
            @(negedge clk);
            #1;
            if (ddr.O_cmd_en !== 1'b0 || O_gnt !== 2'b00) seen++;
        end
        n_tests++;
        if (seen != 0) begin n_fail++; $display("FAIL calib_gate cmd_en cycles %0d want 0", seen); end
        I_init_calib_complete = 1'b1;
        for (int c = 0; c < 30 && second < 0; c++) begin
            @(negedge clk);
            if (drop0) I_req[0] = 1'b0;
            if (drop1) I_req[1] = 1'b0;
            #1;
            if (O_gnt != 2'b00) begin
                if (first < 0) first = O_gnt[1] ? 1 : 0;
                else           second = O_gnt[1] ? 1 : 0;
                exp_q.push_back(O_gnt[1] ? 1 : 0);
                if (O_gnt[0]) drop0 = 1'b1;
                if (O_gnt[1]) drop1 = 1'b1;
            end
        end
        @(negedge clk);
        I_req = 2'b00;
        n_tests++;
        if (first != 0) begin n_fail++; $display("FAIL calib_first_grant got %0d want 0", first); end
        n_tests++;
        if (second != 1) begin n_fail++; $display("FAIL calib_second_grant got %0d want 1", second); end
        drain_reads(2, bad, av, wv);
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL calib_read_route got %b want %b (%0d bad)", av, wv, bad); end
    endtask

    task automatic test_single_write();
        bit g, a, e, d, o;
        int beats;
        run_write(0, 3, 28'h0001000, 1, g, a, beats, e, d, o);
        n_tests++;
        if (!(g && a)) begin n_fail++; $display("FAIL write_grant got gnt=%0d cmd_ok=%0d want 1 1", g, a); end
        n_tests++;
        if (beats != 4) begin n_fail++; $display("FAIL write_beats got %0d want 4", beats); end
        n_tests++;
        if (!(e && d)) begin n_fail++; $display("FAIL write_end_data got end_ok=%0d data_ok=%0d want 1 1", e, d); end
        n_tests++;
        if (!o) begin n_fail++; $display("FAIL write_other_rdy got nonzero want 0"); end
    endtask

    task automatic test_interleaved_reads();
        bit ok0, ok1, okr;
        int bad, p, b;
        logic [1:0] av, wv;
        issue_read(0, 1, ok0);
        issue_read(1, 2, ok1);
        n_tests++;
        if (!(ok0 && ok1)) begin n_fail++; $display("FAIL ilv_issue got %0d%0d want 11", ok0, ok1); end
        drain_reads(5, bad, av, wv);
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL ilv_route got %b want %b (%0d bad)", av, wv, bad); end
        okr = 1'b1;
        for (int k = 0; k < 3; k++) begin
            p = $urandom_range(0, 1);
            b = $urandom_range(0, 3);
            issue_read(p, b, ok0);
            okr = okr & ok0;
        end
        n_tests++;
        if (!okr) begin n_fail++; $display("FAIL rand_issue got 0 want 1"); end
        b = exp_q.size();
        drain_reads(b, bad, av, wv);
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL rand_route got %b want %b (%0d bad)", av, wv, bad); end
    endtask

    task automatic test_tag_full();
        bit ok, okall, g, a, e, d, o, got;
        int beats, g1, bad;
        logic [1:0] av, wv;
        okall = 1'b1;
        for (int k = 0; k < 4; k++) begin issue_read(1, 0, ok); okall = okall & ok; end
        n_tests++;
        if (!okall) begin n_fail++; $display("FAIL full_fill got 0 want 1"); end
        I_rnw[1] = 1'b1; I_burst[11:6] = 6'd0; I_req[1] = 1'b1;
        g1 = gnt_cnt[1];
        run_write(0, 2, 28'($urandom), 2, g, a, beats, e, d, o);
        n_tests++;
        if (!(g && beats == 3)) begin n_fail++; $display("FAIL full_write_meanwhile got gnt=%0d beats=%0d want 1 3", g, beats); end
        repeat (10) @(negedge clk);
        n_tests++;
        if (gnt_cnt[1] != g1) begin n_fail++; $display("FAIL full_blocked got %0d grants want 0", gnt_cnt[1] - g1); end
        drain_reads(1, bad, av, wv);
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            #1;
            if (O_gnt[1] === 1'b1) begin got = 1'b1; exp_q.push_back(1); end
        end
        @(negedge clk);
        I_req[1] = 1'b0;
        n_tests++;
        if (!got || bad != 0) begin n_fail++; $display("FAIL full_after_pop got gnt=%0d bad=%0d want 1 0", got, bad); end
        drain_reads(4, bad, av, wv);
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL full_drain got %b want %b (%0d bad)", av, wv, bad); end
    endtask

    task automatic test_boundary();
        bit g, a, e, d, o;
        int beats;
        run_write(1, 63, 28'($urandom), 2, g, a, beats, e, d, o);
        n_tests++;
        if (!(g && a)) begin n_fail++; $display("FAIL b63_grant got gnt=%0d cmd_ok=%0d want 1 1", g, a); end
        n_tests++;
        if (beats != 64) begin n_fail++; $display("FAIL b63_beats got %0d want 64", beats); end
        n_tests++;
        if (!(e && d && o)) begin n_fail++; $display("FAIL b63_end got end=%0d data=%0d other=%0d want 1 1 1", e, d, o); end
        @(negedge clk);
        ddr.I_rd_data_valid = 1'b1;
        ddr.I_rd_data = r128();
        @(negedge clk);
        ddr.I_rd_data_valid = 1'b0;
        #1;
        n_tests++;
        if (O_rd_valid !== 2'b00 || O_err !== 1'b1) begin
            n_fail++; $display("FAIL empty_beat got valid=%b err=%b want 00 1", O_rd_valid, O_err);
        end
        repeat (5) @(negedge clk);
        #1;
        n_tests++;
        if (O_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", O_err); end
    endtask

    task automatic test_reset_mid();
        bit granted, drop, done;
        int beats, first, bad;
        logic [1:0] av, wv;
        granted = 1'b0; drop = 1'b0; done = 1'b0; beats = 0; first = -1;
        I_rnw[0] = 1'b0; I_burst[5:0] = 6'd7; I_req[0] = 1'b1; I_wr_en = 2'b01;
        ddr.I_wr_data_rdy = 1'b1;
        for (int c = 0; c < 30 && !done; c++) begin
            @(negedge clk);
            if (drop) I_req[0] = 1'b0;
            if (beats == 1) begin I_rst = 1'b1; done = 1'b1; end
            #1;
            if (O_gnt[0] === 1'b1) begin granted = 1'b1; drop = 1'b1; end
            if (ddr.O_wr_data_en === 1'b1) beats++;
        end
        @(negedge clk);
        I_rst = 1'b0;
        I_req = 2'b00;
        #1;
        n_tests++;
        if (!granted || !done) begin n_fail++; $display("FAIL rstmid_setup got gnt=%0d reached=%0d want 1 1", granted, done); end
        n_tests++;
        if ({O_gnt, O_wr_rdy, O_rd_valid, ddr.O_cmd_en, ddr.O_wr_data_en, ddr.O_wr_data_end, O_err} !== 9'd0
            || {ddr.O_cmd, ddr.O_addr, ddr.O_app_burst_number} !== 37'd0) begin
            n_fail++; $display("FAIL rstmid_outputs got flags=%b cmd=%h want 0", {O_gnt, O_wr_rdy, O_rd_valid, ddr.O_cmd_en,
                ddr.O_wr_data_en, ddr.O_wr_data_end, O_err}, {ddr.O_cmd, ddr.O_addr, ddr.O_app_burst_number});
        end
        I_wr_en = 2'b00;
        I_rnw = 2'b11; I_burst = 12'd0; I_req = 2'b11;
        for (int c = 0; c < 20 && first < 0; c++) begin
            @(negedge clk);
            #1;
            if (O_gnt != 2'b00) begin first = O_gnt[1] ? 1 : 0; exp_q.push_back(first); end
        end
        @(negedge clk);
        I_req[first == 1 ? 1 : 0] = 1'b0;
        for (int c = 0; c < 20 && exp_q.size() < 2; c++) begin
            @(negedge clk);
            #1;
            if (O_gnt != 2'b00) exp_q.push_back(O_gnt[1] ? 1 : 0);
        end
        @(negedge clk);
        I_req = 2'b00;
        n_tests++;
        if (first != 0) begin n_fail++; $display("FAIL rstmid_next_grant got %0d want 0", first); end
        drain_reads(2, bad, av, wv);
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL rstmid_reads got %b want %b (%0d bad)", av, wv, bad); end
    endtask

    initial begin
        I_rst = 1'b1; I_init_calib_complete = 1'b1;
        I_req = 2'b00; I_rnw = 2'b00; I_addr = '0; I_burst = '0;
        I_wr_en = 2'b00; I_wr_data = '0; I_wr_mask = '0;
        ddr.I_cmd_ready = 1'b1; ddr.I_wr_data_rdy = 1'b1;
        ddr.I_rd_data_valid = 1'b0; ddr.I_rd_data = '0;
        test_reset();
        test_calib_gate();
        test_single_write();
        test_interleaved_reads();
        test_tag_full();
        test_boundary();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
